// File: rtl/if_id_buffer.sv
// Two-entry elastic IF/ID pipeline register: slot0 is the head presented to decode,
// slot1 absorbs one cycle of back-pressure. Optional stall counter under IFID_STALL_CNT_EN.
module if_id_buffer #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] NOP_INSTR = 'h13
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid_i,
  input  logic [XLEN-1:0] if_pc_plus_4_i,
  input  logic [XLEN-1:0] if_instr_i,
  output logic            if_ready_o,
  input  logic            flush_i,
  output logic            id_valid_o,
  output logic [XLEN-1:0] id_pc_plus_4_o,
  output logic [XLEN-1:0] id_pc_o,
  output logic [XLEN-1:0] id_instr_o,
  input  logic            id_ready_i,
  output logic [31:0]     stall_cnt_o
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // ready never depends combinationally on the opposite side's valid or ready.
  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] slot0_pc4_q, slot0_pc4_d, slot0_instr_q, slot0_instr_d;
  logic [XLEN-1:0] slot1_pc4_q, slot1_pc4_d, slot1_instr_q, slot1_instr_d;
  logic            push, pop;

  assign push = if_valid_i & if_ready_o;
  assign pop  = id_valid_o & id_ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_EMPTY;
      slot0_pc4_q   <= '0;
      slot0_instr_q <= '0;
      slot1_pc4_q   <= '0;
      slot1_instr_q <= '0;
    end else begin
      state_q       <= state_d;
      slot0_pc4_q   <= slot0_pc4_d;
      slot0_instr_q <= slot0_instr_d;
      slot1_pc4_q   <= slot1_pc4_d;
      slot1_instr_q <= slot1_instr_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    slot0_pc4_d   = slot0_pc4_q;
    slot0_instr_d = slot0_instr_q;
    slot1_pc4_d   = slot1_pc4_q;
    slot1_instr_d = slot1_instr_q;
    if (flush_i) begin
      // Slot data is left alone; only occupancy matters once flushed.
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d       = ST_ONE;
            slot0_pc4_d   = if_pc_plus_4_i;
            slot0_instr_d = if_instr_i;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            slot0_pc4_d   = if_pc_plus_4_i;
            slot0_instr_d = if_instr_i;
          end else if (push) begin
            state_d       = ST_FULL;
            slot1_pc4_d   = if_pc_plus_4_i;
            slot1_instr_d = if_instr_i;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            state_d       = ST_ONE;
            slot0_pc4_d   = slot1_pc4_q;
            slot0_instr_d = slot1_instr_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    if_ready_o     = (state_q != ST_FULL) && !rst;
    id_valid_o     = (state_q != ST_EMPTY);
    id_pc_plus_4_o = slot0_pc4_q;
    id_pc_o        = id_valid_o ? (slot0_pc4_q - XLEN'(4)) : RESET_PC;
    id_instr_o     = id_valid_o ? slot0_instr_q : NOP_INSTR;
  end

`ifdef IFID_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (id_valid_o && !id_ready_i && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Bench for if_id_buffer: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_if_id_buffer;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_valid_i = 1'b0;
  logic [31:0] if_pc_plus_4_i = '0;
  logic [31:0] if_instr_i = '0;
  logic        if_ready_o;
  logic        flush_i = 1'b0;
  logic        id_valid_o;
  logic [31:0] id_pc_plus_4_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_instr_o;
  logic        id_ready_i = 1'b0;
  logic [31:0] stall_cnt_o;

  int tests = 0;
  int fails = 0;

  // Reference model: FIFO of {pc_plus_4, instr}, capacity two.
  logic [63:0] exp_q[$];
  logic [31:0] exp_cnt = '0;

  if_id_buffer dut (
    .clk(clk), .rst(rst),
    .if_valid_i(if_valid_i), .if_pc_plus_4_i(if_pc_plus_4_i), .if_instr_i(if_instr_i),
    .if_ready_o(if_ready_o), .flush_i(flush_i),
    .id_valid_o(id_valid_o), .id_pc_plus_4_o(id_pc_plus_4_o), .id_pc_o(id_pc_o),
    .id_instr_o(id_instr_o), .id_ready_i(id_ready_i), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update at each clock edge, from the rules of the buffer.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      exp_cnt <= '0;
    end else begin
      logic do_push, do_pop;
      do_push = if_valid_i && (exp_q.size() < 2);
      do_pop  = (exp_q.size() > 0) && id_ready_i;
      if ((exp_q.size() > 0) && !id_ready_i && exp_cnt != 32'hFFFF_FFFF)
        exp_cnt <= exp_cnt + 1;
      if (flush_i) exp_q.delete();
      else begin
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) exp_q.push_back({if_pc_plus_4_i, if_instr_i});
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    logic [63:0] head;
    chk("id_valid", {31'b0, id_valid_o}, {31'b0, exp_q.size() != 0});
    chk("if_ready", {31'b0, if_ready_o}, {31'b0, !rst && exp_q.size() < 2});
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      chk("id_pc_plus_4", id_pc_plus_4_o, head[63:32]);
      chk("id_instr", id_instr_o, head[31:0]);
      chk("id_pc", id_pc_o, head[63:32] - 32'd4);
    end else begin
      chk("id_instr_empty", id_instr_o, NOP);
      chk("id_pc_empty", id_pc_o, 32'h0);
    end
`ifdef IFID_STALL_CNT_EN
    chk("stall_cnt", stall_cnt_o, exp_cnt);
`else
    chk("stall_cnt_off", stall_cnt_o, 32'h0);
`endif
  end

  task automatic cyc(input logic v, input logic [31:0] p, input logic [31:0] ins,
                     input logic rdy, input logic fl);
    if_valid_i = v; if_pc_plus_4_i = p; if_instr_i = ins; id_ready_i = rdy; flush_i = fl;
    @(negedge clk); #1;
  endtask

  task automatic head_is(input string name, input logic [31:0] pc, input logic [31:0] ins);
    chk({name, "_valid"}, {31'b0, id_valid_o}, 32'd1);
    chk({name, "_pc"}, id_pc_o, pc);
    chk({name, "_instr"}, id_instr_o, ins);
  endtask

  task automatic do_reset();
    if_valid_i = 1'b0; flush_i = 1'b0; id_ready_i = 1'b0;
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] r, p;
    @(negedge clk); @(negedge clk); #1;
    chk("rst_valid", {31'b0, id_valid_o}, 32'd0);
    chk("rst_pc4", id_pc_plus_4_o, 32'h0);
    chk("rst_ready", {31'b0, if_ready_o}, 32'd0);
    rst = 1'b0;
    #1 chk("rel_ready", {31'b0, if_ready_o}, 32'd1);

    // Streaming, no bubbles
    cyc(1, 32'd4,  32'h0050_0093, 1, 0); head_is("s0", 32'd0, 32'h0050_0093);
    chk("s0_ready", {31'b0, if_ready_o}, 32'd1);
    cyc(1, 32'd8,  32'h00A0_0113, 1, 0); head_is("s1", 32'd4, 32'h00A0_0113);
    cyc(1, 32'd12, 32'h0020_81B3, 1, 0); head_is("s2", 32'd8, 32'h0020_81B3);
    chk("s2_ready", {31'b0, if_ready_o}, 32'd1);
    cyc(0, 32'd0, 32'd0, 1, 0);
    chk("s_drain", {31'b0, id_valid_o}, 32'd0);

    // Back-pressure
    cyc(1, 32'h20, 32'hAAAA_0001, 0, 0); head_is("bp_a", 32'h1C, 32'hAAAA_0001);
    cyc(1, 32'h24, 32'hBBBB_0002, 0, 0);
    chk("bp_full_ready", {31'b0, if_ready_o}, 32'd0);
    cyc(1, 32'h28, 32'hCCCC_0003, 0, 0); head_is("bp_hold", 32'h1C, 32'hAAAA_0001);
    cyc(1, 32'h28, 32'hCCCC_0003, 1, 0); head_is("bp_b", 32'h20, 32'hBBBB_0002);
    cyc(1, 32'h28, 32'hCCCC_0003, 1, 0); head_is("bp_c", 32'h24, 32'hCCCC_0003);
    cyc(0, 32'd0, 32'd0, 1, 0);
    chk("bp_drain", {31'b0, id_valid_o}, 32'd0);

    // Flush while full with a pending offer
    cyc(1, 32'h40, 32'h1111_0001, 0, 0);
    cyc(1, 32'h44, 32'h2222_0002, 0, 0);
    cyc(1, 32'h48, 32'h3333_0003, 0, 1);
    chk("fl_valid", {31'b0, id_valid_o}, 32'd0);
    chk("fl_instr", id_instr_o, NOP);
    chk("fl_pc", id_pc_o, 32'h0);
    cyc(1, 32'h100, 32'h4444_0004, 0, 0); head_is("fl_d", 32'hFC, 32'h4444_0004);
    cyc(0, 32'd0, 32'd0, 1, 0);
    chk("fl_d_alone", {31'b0, id_valid_o}, 32'd0);

    // PC wrap
    cyc(1, 32'h0, 32'h5555_0005, 1, 0); head_is("wrap", 32'hFFFF_FFFC, 32'h5555_0005);
    cyc(0, 32'd0, 32'd0, 1, 0);

    // Asynchronous reset with two entries held
    cyc(1, 32'h60, 32'h6666_0006, 0, 0);
    cyc(1, 32'h64, 32'h7777_0007, 0, 0);
    if_valid_i = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'b0, id_valid_o}, 32'd0);
    chk("arst_instr", id_instr_o, NOP);
    chk("arst_pc", id_pc_o, 32'h0);
    chk("arst_ready", {31'b0, if_ready_o}, 32'd0);
    @(negedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    chk("arst_rel_ready", {31'b0, if_ready_o}, 32'd1);
    chk("arst_rel_valid", {31'b0, id_valid_o}, 32'd0);

    // Stall counter: one entry held for seven cycles, then flush
    do_reset();
    cyc(1, 32'h80, 32'h8888_0008, 0, 0);
    repeat (7) cyc(0, 32'd0, 32'd0, 0, 0);
`ifdef IFID_STALL_CNT_EN
    chk("stall_7", stall_cnt_o, 32'd7);
    cyc(0, 32'd0, 32'd0, 1, 1);
    chk("stall_after_flush", stall_cnt_o, 32'd7);
`else
    chk("stall_off", stall_cnt_o, 32'd0);
    cyc(0, 32'd0, 32'd0, 1, 1);
    chk("stall_off_flush", stall_cnt_o, 32'd0);
`endif
    chk("stall_flush_valid", {31'b0, id_valid_o}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom;
      p = {r[31:2], 2'b00};
      if ($urandom_range(0, 15) == 0) p = 32'h0;
      cyc($urandom_range(0, 3) != 0, p, $urandom, $urandom_range(0, 2) != 0,
          $urandom_range(0, 19) == 0);
    end

    repeat (3) cyc(0, 32'd0, 32'd0, 1, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
